// File: rtl/ts_packet_sync_pkg.sv
// Shared definitions for the TS packet synchroniser: the MPEG-TS sync byte,
// the HUNT/VERIFY/LOCK state encodings and the byte-counter wrap helper.
package ts_packet_sync_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    // Byte counter advance: wraps to 0 after the last byte of a packet.
    function automatic logic [7:0] bc_next(input logic [7:0] bc, input logic [7:0] last);
        return (bc == last) ? 8'd0 : bc + 8'd1;
    endfunction

endpackage

// File: rtl/ts_packet_sync_edge_sync.sv
// Two-flop synchroniser into the clk domain with a rising-edge detector per bit.
// sync is the synchronised level; rise is high for one clk when sync goes 0->1.
module edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;

    // Metastability chain plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/ts_packet_sync.sv
// TS packet synchroniser: brings an asynchronous byte stream into the CLK
// domain, hunts for the 0x47 sync byte, verifies LOCK_CNT consecutive packets,
// then emits aligned bytes with a packet-start strobe while locked.
// Optional build macro TS_ERR_COUNT_EN adds the saturating ERR_CNT output.
// dbg_state exposes the acquisition FSM state.
module ts_packet_sync
    import ts_packet_sync_pkg::*;
#(
    parameter int PKT_LEN  = 188,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RESET_ON_CHANGE,
    input  logic [7:0]  DATA_IN,
    input  logic        DCLK_IN,
    input  logic        D_VALID_IN,
    input  logic        P_SYNC_IN,
    output logic [7:0]  DATA_OUT,
    output logic        D_VALID_OUT,
    output logic        P_SYNC_OUT,
    output logic        LOCK,
`ifdef TS_ERR_COUNT_EN
    output logic [15:0] ERR_CNT,
`endif
    output state_t      dbg_state
);

    localparam logic [7:0] LAST_BC = 8'(PKT_LEN - 1);
    localparam logic [7:0] LOCK_TH = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TH = 8'(LOSS_CNT);

    // Control lines: bit 0 DCLK, bit 1 D_VALID, bit 2 P_SYNC.
    logic [2:0] ctl_sync;
    logic [2:0] ctl_rise;
    logic [7:0] data_s1;
    logic [7:0] data_s2;
    logic       bs;
    logic       unused_bits;

    edge_sync #(.WIDTH(3)) u_ctl_sync (
        .clk      (CLK),
        .rst_n    (RST),
        .async_in ({P_SYNC_IN, D_VALID_IN, DCLK_IN}),
        .sync     (ctl_sync),
        .rise     (ctl_rise)
    );

    // Data bus synchroniser; the source holds DATA_IN stable around the DCLK edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
        end else begin
            data_s1 <= DATA_IN;
            data_s2 <= data_s1;
        end
    end

    assign bs          = ctl_rise[0] & ctl_sync[1];
    assign unused_bits = &{1'b0, ctl_sync[0], ctl_rise[2:1]};

    state_t     state;
    state_t     state_n;
    logic [7:0] bc;
    logic [7:0] bc_n;
    logic [7:0] good;
    logic [7:0] good_n;
    logic [7:0] bad;
    logic [7:0] bad_n;
    logic [7:0] data_n;
    logic       dv_n;
    logic       ps_n;
`ifdef TS_ERR_COUNT_EN
    logic [15:0] err_n;
`endif

    // State, counters and output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= ST_HUNT;
            bc          <= 8'd0;
            good        <= 8'd0;
            bad         <= 8'd0;
            DATA_OUT    <= 8'h00;
            D_VALID_OUT <= 1'b0;
            P_SYNC_OUT  <= 1'b0;
`ifdef TS_ERR_COUNT_EN
            ERR_CNT     <= 16'h0000;
`endif
        end else begin
            state       <= state_n;
            bc          <= bc_n;
            good        <= good_n;
            bad         <= bad_n;
            DATA_OUT    <= data_n;
            D_VALID_OUT <= dv_n;
            P_SYNC_OUT  <= ps_n;
`ifdef TS_ERR_COUNT_EN
            ERR_CNT     <= err_n;
`endif
        end
    end

    // Acquisition FSM: next state, counters and output strobes per byte strobe.
    always_comb begin
        state_n = state;
        bc_n    = bc;
        good_n  = good;
        bad_n   = bad;
        data_n  = DATA_OUT;
        dv_n    = 1'b0;
        ps_n    = 1'b0;
`ifdef TS_ERR_COUNT_EN
        err_n   = ERR_CNT;
`endif
        if (RESET_ON_CHANGE) begin
            // Channel change wins over any byte arriving in the same cycle.
            state_n = ST_HUNT;
            bc_n    = 8'd0;
            good_n  = 8'd0;
            bad_n   = 8'd0;
`ifdef TS_ERR_COUNT_EN
            err_n   = 16'h0000;
`endif
        end else if (bs) begin
            case (state)
                ST_HUNT: begin
                    if (ctl_sync[2] && data_s2 == TS_SYNC_BYTE) begin
                        state_n = ST_VERIFY;
                        bc_n    = 8'd1;
                        good_n  = 8'd1;
                        bad_n   = 8'd0;
                    end
                end
                ST_VERIFY: begin
                    bc_n = bc_next(bc, LAST_BC);
                    if (bc == 8'd0) begin
                        if (data_s2 == TS_SYNC_BYTE) begin
                            good_n = good + 8'd1;
                            if (good_n >= LOCK_TH) begin
                                state_n = ST_LOCK;
                                bad_n   = 8'd0;
                            end
                        end else begin
                            state_n = ST_HUNT;
                            bc_n    = 8'd0;
                            good_n  = 8'd0;
                        end
                    end
                end
                ST_LOCK: begin
                    // Alignment follows BC only; P_SYNC_IN is not consulted here.
                    bc_n   = bc_next(bc, LAST_BC);
                    data_n = data_s2;
                    dv_n   = 1'b1;
                    ps_n   = (bc == 8'd0);
                    if (bc == 8'd0) begin
                        if (data_s2 == TS_SYNC_BYTE) begin
                            bad_n = 8'd0;
                        end else begin
                            bad_n = bad + 8'd1;
`ifdef TS_ERR_COUNT_EN
                            if (ERR_CNT != 16'hFFFF) begin
                                err_n = ERR_CNT + 16'd1;
                            end
`endif
                            if (bad_n >= LOSS_TH) begin
                                state_n = ST_HUNT;
                                bc_n    = 8'd0;
                                good_n  = 8'd0;
                                bad_n   = 8'd0;
                            end
                        end
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                    bc_n    = 8'd0;
                    good_n  = 8'd0;
                    bad_n   = 8'd0;
                end
            endcase
        end
    end

    assign LOCK      = (state == ST_LOCK);
    assign dbg_state = state;

endmodule

// File: tb/tb_ts_packet_sync.sv
// Bench for ts_packet_sync: packet-level vector table plus hand-written
// sequences for channel change, mid-packet reset and HUNT/VERIFY corners.
// Output bytes are checked through an expected queue of {p_sync, data}.
module tb_ts_packet_sync;
    import ts_packet_sync_pkg::*;

    localparam int PKT_LEN = 188;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RESET_ON_CHANGE = 1'b0;
    logic [7:0]  DATA_IN = 8'h00;
    logic        DCLK_IN = 1'b0;
    logic        D_VALID_IN = 1'b0;
    logic        P_SYNC_IN = 1'b0;
    logic [7:0]  DATA_OUT;
    logic        D_VALID_OUT;
    logic        P_SYNC_OUT;
    logic        LOCK;
    state_t      dbg_state;
`ifdef TS_ERR_COUNT_EN
    logic [15:0] ERR_CNT;
`endif

    ts_packet_sync #(.PKT_LEN(PKT_LEN), .LOCK_CNT(3), .LOSS_CNT(3)) dut (
`ifdef TS_ERR_COUNT_EN
        .ERR_CNT         (ERR_CNT),
`endif
        .CLK             (CLK),
        .RST             (RST),
        .RESET_ON_CHANGE (RESET_ON_CHANGE),
        .DATA_IN         (DATA_IN),
        .DCLK_IN         (DCLK_IN),
        .D_VALID_IN      (D_VALID_IN),
        .P_SYNC_IN       (P_SYNC_IN),
        .DATA_OUT        (DATA_OUT),
        .D_VALID_OUT     (D_VALID_OUT),
        .P_SYNC_OUT      (P_SYNC_OUT),
        .LOCK            (LOCK),
        .dbg_state       (dbg_state)
    );

    // Clock and watchdog.
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=done");
        $fatal(1);
    end

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0]  sync;      // value placed in byte 0 (P_SYNC_IN always set there)
        logic        exp_lock;  // LOCK expected once byte 0 has been processed
        int          out_lo;    // first byte index expected on the output
        int          out_hi;    // one past the last byte index expected on the output
        logic [15:0] exp_err;   // ERR_CNT expected at end of packet
    } pkt_vec_t;

    pkt_vec_t tab[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output strobe must match the head of the expected queue.
    always @(negedge CLK) begin
        if (D_VALID_OUT) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe actual=%0h required=none", {P_SYNC_OUT, DATA_OUT});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({P_SYNC_OUT, DATA_OUT} !== e) begin
                    bad++;
                    $display("FAIL out_byte actual=%0h required=%0h", {P_SYNC_OUT, DATA_OUT}, e);
                end
            end
        end else if (P_SYNC_OUT) begin
            total++;
            bad++;
            $display("FAIL psync_without_valid actual=1 required=0");
        end
    end

    // One source byte: 2 CLK with DCLK low, then DCLK high; returns just before the strobe edge.
    task automatic send_byte(input logic [7:0] d, input logic v, input logic p);
        @(negedge CLK);
        DATA_IN    = d;
        D_VALID_IN = v;
        P_SYNC_IN  = p;
        DCLK_IN    = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        DCLK_IN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic send_packet(input int idx);
        logic [7:0] d;
        for (int i = 0; i < PKT_LEN; i++) begin
            d = (i == 0) ? tab[idx].sync : 8'($urandom_range(0, 255));
            if (i >= tab[idx].out_lo && i < tab[idx].out_hi) exp_q.push_back({(i == 0), d});
            send_byte(d, 1'b1, (i == 0));
            if (i == 1) check($sformatf("lock_pkt%0d", idx), 32'(LOCK), 32'(tab[idx].exp_lock));
        end
`ifdef TS_ERR_COUNT_EN
        check($sformatf("err_pkt%0d", idx), 32'(ERR_CNT), 32'(tab[idx].exp_err));
`endif
    endtask

    initial begin
        logic [7:0] d;
        // Acquisition and loss of lock.
        tab[0]  = '{8'h47, 1'b0, PKT_LEN, PKT_LEN, 16'd0};
        tab[1]  = '{8'h47, 1'b0, PKT_LEN, PKT_LEN, 16'd0};
        tab[2]  = '{8'h47, 1'b1, 1,       PKT_LEN, 16'd0};
        tab[3]  = '{8'h47, 1'b1, 0,       PKT_LEN, 16'd0};
        tab[4]  = '{8'h47, 1'b1, 0,       PKT_LEN, 16'd0};
        tab[5]  = '{8'h00, 1'b1, 0,       PKT_LEN, 16'd1};
        tab[6]  = '{8'h00, 1'b1, 0,       PKT_LEN, 16'd2};
        tab[7]  = '{8'h00, 1'b0, 0,       1,       16'd3};
        tab[8]  = '{8'h47, 1'b0, PKT_LEN, PKT_LEN, 16'd3};
        tab[9]  = '{8'h47, 1'b0, PKT_LEN, PKT_LEN, 16'd3};
        tab[10] = '{8'h47, 1'b1, 1,       PKT_LEN, 16'd3};
        // Relock after channel change, then two bad syncs recovered by a good one.
        tab[11] = '{8'h47, 1'b0, PKT_LEN, PKT_LEN, 16'd0};
        tab[12] = '{8'h47, 1'b0, PKT_LEN, PKT_LEN, 16'd0};
        tab[13] = '{8'h47, 1'b1, 1,       PKT_LEN, 16'd0};
        tab[14] = '{8'h00, 1'b1, 0,       PKT_LEN, 16'd1};
        tab[15] = '{8'h00, 1'b1, 0,       PKT_LEN, 16'd2};
        tab[16] = '{8'h47, 1'b1, 0,       PKT_LEN, 16'd2};

        // Reset state.
        repeat (4) @(negedge CLK);
        check("rst_data",  32'(DATA_OUT), 32'h00);
        check("rst_valid", 32'(D_VALID_OUT), 32'd0);
        check("rst_psync", 32'(P_SYNC_OUT), 32'd0);
        check("rst_lock",  32'(LOCK), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_HUNT));
`ifdef TS_ERR_COUNT_EN
        check("rst_err",   32'(ERR_CNT), 32'd0);
`endif
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        for (int k = 0; k <= 10; k++) send_packet(k);

        // Channel change coincident with the strobe of byte 50 of a locked packet.
        for (int i = 0; i < 50; i++) begin
            d = (i == 0) ? 8'h47 : 8'($urandom_range(0, 255));
            exp_q.push_back({(i == 0), d});
            send_byte(d, 1'b1, (i == 0));
        end
        send_byte(8'h5A, 1'b1, 1'b0);
        RESET_ON_CHANGE = 1'b1;
        @(negedge CLK);
        RESET_ON_CHANGE = 1'b0;
        check("roc_valid", 32'(D_VALID_OUT), 32'd0);
        check("roc_lock",  32'(LOCK), 32'd0);
        check("roc_state", 32'(dbg_state), 32'(ST_HUNT));
`ifdef TS_ERR_COUNT_EN
        check("roc_err",   32'(ERR_CNT), 32'd0);
`endif
        for (int i = 51; i < PKT_LEN; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);

        for (int k = 11; k <= 16; k++) send_packet(k);

        // Reset at byte 100 of a locked packet.
        for (int i = 0; i < 100; i++) begin
            d = (i == 0) ? 8'h47 : 8'($urandom_range(1, 255));
            exp_q.push_back({(i == 0), d});
            send_byte(d, 1'b1, (i == 0));
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_data",  32'(DATA_OUT), 32'h00);
        check("mid_rst_valid", 32'(D_VALID_OUT), 32'd0);
        check("mid_rst_psync", 32'(P_SYNC_OUT), 32'd0);
        check("mid_rst_lock",  32'(LOCK), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_HUNT));
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        for (int i = 100; i < PKT_LEN; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        @(negedge CLK);
        check("post_rst_state", 32'(dbg_state), 32'(ST_HUNT));

        // 0x47 without P_SYNC_IN must not start verification.
        repeat (3) send_byte(8'h47, 1'b1, 1'b0);
        @(negedge CLK);
        check("hunt_no_psync", 32'(dbg_state), 32'(ST_HUNT));
        send_byte(8'h47, 1'b1, 1'b1);
        @(negedge CLK);
        check("hunt_to_verify", 32'(dbg_state), 32'(ST_VERIFY));
        // DCLK edges with D_VALID_IN low must not advance the byte counter.
        repeat (10) send_byte(8'hA5, 1'b0, 1'b0);
        repeat (PKT_LEN - 1) send_byte(8'hA5, 1'b1, 1'b0);
        @(negedge CLK);
        check("invalid_no_advance", 32'(dbg_state), 32'(ST_VERIFY));
        send_byte(8'h47, 1'b1, 1'b1);
        @(negedge CLK);
        check("verify_second_sync", 32'(dbg_state), 32'(ST_VERIFY));
        check("verify_no_lock", 32'(LOCK), 32'd0);

        repeat (10) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
